// File: rtl/seq_mon_pkg.sv
// Shared types and helpers for the sequence-hit monitor.
package seq_mon_pkg;

   typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} win_state_t;
   typedef enum logic {RPT_EMPTY = 1'b0, RPT_FULL = 1'b1} rpt_state_t;

   // Increment v by inc, holding at maxv instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                           input logic        inc,
                                           input logic [31:0] maxv);
      logic [31:0] r;
      r = v;
      if (inc && (v < maxv)) r = v + 32'd1;
      return r;
   endfunction

endpackage

// File: rtl/seq_rpt_slot.sv
// Single-entry valid/ready report register; flags a load that replaces an unaccepted entry.
module seq_rpt_slot
   import seq_mon_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_data,
   input  logic             ready,
   output logic             valid,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);

   rpt_state_t state;

   assign valid = (state == RPT_FULL);
   // Overwrite only when the held entry is not consumed in the same cycle.
   assign ovf   = load && valid && !ready && !clr;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= RPT_EMPTY;
         count <= '0;
      end else if (clr) begin
         state <= RPT_EMPTY;
         count <= '0;
      end else if (load) begin
         state <= RPT_FULL;
         count <= load_data;
      end else if (valid && ready) begin
         state <= RPT_EMPTY;
      end
   end

endmodule

// File: rtl/seq_hit_monitor.sv
// Counts registered detector hits per window of enabled cycles, reports each window,
// keeps a saturating lifetime total and a sticky threshold alarm.
module seq_hit_monitor
   import seq_mon_pkg::*;
#(
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned WINDOW = 64,
   parameter int unsigned THRESH = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             hit,
   input  logic             clr,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [CNT_W-1:0] rpt_count,
   output logic             rpt_ovf,
   output logic             alarm,
   output logic [CNT_W-1:0] total_hits
);

   localparam int unsigned      TW    = $clog2(WINDOW);
   localparam logic [CNT_W-1:0] CMAX  = '1;
   localparam logic [CNT_W-1:0] THR   = CNT_W'(THRESH);
   localparam logic [TW-1:0]    TLAST = TW'(WINDOW - 1);

   win_state_t       state;
   logic [TW-1:0]    timer;
   logic [CNT_W-1:0] win_cnt;
   logic [CNT_W-1:0] win_next;
   logic [CNT_W-1:0] tot_next;
   logic             counting;
   logic             load;
   logic             slot_ovf;

   assign counting = (state == COUNT) && en && !clr;
   assign load     = counting && (timer == TLAST);

   always_comb begin
      win_next = CNT_W'(sat_inc(32'(win_cnt), hit, 32'(CMAX)));
      tot_next = CNT_W'(sat_inc(32'(total_hits), hit, 32'(CMAX)));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         timer      <= '0;
         win_cnt    <= '0;
         total_hits <= '0;
         alarm      <= 1'b0;
         rpt_ovf    <= 1'b0;
      end else if (clr) begin
         state      <= en ? COUNT : IDLE;
         timer      <= '0;
         win_cnt    <= '0;
         total_hits <= '0;
         alarm      <= 1'b0;
         rpt_ovf    <= 1'b0;
      end else begin
         if (slot_ovf) rpt_ovf <= 1'b1;
         if (state == IDLE) begin
            if (en) begin
               state   <= COUNT;
               timer   <= '0;
               win_cnt <= '0;
            end
         end else if (!en) begin
            state   <= IDLE;
            timer   <= '0;
            win_cnt <= '0;
         end else begin
            total_hits <= tot_next;
            if (win_next >= THR) alarm <= 1'b1;
            // The closing hit is folded into the report, then the window restarts.
            if (timer == TLAST) begin
               timer   <= '0;
               win_cnt <= '0;
            end else begin
               timer   <= timer + TW'(1);
               win_cnt <= win_next;
            end
         end
      end
   end

   seq_rpt_slot #(
      .CNT_W (CNT_W)
   ) u_slot (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (clr),
      .load      (load),
      .load_data (win_next),
      .ready     (rpt_ready),
      .valid     (rpt_valid),
      .count     (rpt_count),
      .ovf       (slot_ovf)
   );

endmodule

// File: tb/tb_seq_hit_monitor.sv
// Randomized scoreboard bench for seq_hit_monitor against a window-level reference model.
module tb_seq_hit_monitor;

   localparam int CW   = 4;
   localparam int WIN  = 8;
   localparam int TH   = 3;
   localparam int SMAX = 15;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          en = 1'b0, hit = 1'b0, clr = 1'b0, rpt_ready = 1'b0;
   logic          rpt_valid, rpt_ovf, alarm;
   logic [CW-1:0] rpt_count, total_hits;

   always #5 clk = ~clk;

   seq_hit_monitor #(
      .CNT_W  (CW),
      .WINDOW (WIN),
      .THRESH (TH)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .en         (en),
      .hit        (hit),
      .clr        (clr),
      .rpt_valid  (rpt_valid),
      .rpt_ready  (rpt_ready),
      .rpt_count  (rpt_count),
      .rpt_ovf    (rpt_ovf),
      .alarm      (alarm),
      .total_hits (total_hits)
   );

   int tests = 0;
   int fails = 0;
   bit mon_on = 1'b0;

   // Reference model: window position and plain unsaturated hit tallies.
   bit m_active, m_pending, m_alarm, m_ovf;
   int m_pos, m_hits, m_total;
   int exp_q[$];

   function automatic int sat(input int v);
      return (v > SMAX) ? SMAX : v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_active = 0; m_pending = 0; m_alarm = 0; m_ovf = 0;
      m_pos = 0; m_hits = 0; m_total = 0;
      exp_q.delete();
   endfunction

   function automatic void model_step(input bit e, input bit h, input bit c, input bit r);
      bit was_pending;
      if (c) begin
         model_reset();
         m_active = e;
         return;
      end
      was_pending = m_pending;
      if (m_pending && r) m_pending = 0;
      if (!m_active) begin
         if (e) begin
            m_active = 1; m_pos = 0; m_hits = 0;
         end
      end else if (!e) begin
         m_active = 0; m_pos = 0; m_hits = 0;
      end else begin
         m_hits  += h;
         m_total += h;
         if (sat(m_hits) >= TH) m_alarm = 1;
         if (m_pos == WIN - 1) begin
            if (was_pending && !r) begin
               m_ovf = 1;
               if (exp_q.size() > 0) void'(exp_q.pop_back());
            end
            exp_q.push_back(sat(m_hits));
            m_pending = 1;
            m_pos = 0; m_hits = 0;
         end else begin
            m_pos++;
         end
      end
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, rpt_valid, 0);
      check({tag, "_count"}, rpt_count, 0);
      check({tag, "_ovf"},   rpt_ovf, 0);
      check({tag, "_alarm"}, alarm, 0);
      check({tag, "_total"}, total_hits, 0);
   endtask

   // Monitor: state outputs every cycle, report values popped on each accept.
   always @(negedge clk) begin
      if (mon_on) begin
         check("rpt_valid", rpt_valid, m_pending);
         check("alarm", alarm, m_alarm);
         check("rpt_ovf", rpt_ovf, m_ovf);
         check("total_hits", total_hits, sat(m_total));
         if (rpt_valid && rpt_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_report: got count %0d expected no report at %0t",
                        rpt_count, $time);
            end else begin
               check("rpt_count", rpt_count, exp_q.pop_front());
            end
         end
      end
   end

   task automatic drive(input int pen, input int phit, input int pclr, input int prdy);
      en        = ($urandom_range(99) < pen);
      hit       = ($urandom_range(99) < phit);
      clr       = ($urandom_range(99) < pclr);
      rpt_ready = ($urandom_range(99) < prdy);
   endtask

   task automatic async_reset();
      mon_on = 0;
      #2 rstn = 0;
      #1 check_zero("arst");
      drive(100, 100, 0, 50);
      repeat (2) begin
         @(negedge clk);
         check_zero("arst_hold");
         drive(50, 50, 50, 50);
      end
      en = 0; hit = 0; clr = 0; rpt_ready = 0;
      @(negedge clk);
      #1 rstn = 1;
      model_reset();
      mon_on = 1;
   endtask

   // Phases: cycles, en%, hit%, clr%, ready%
   int ph_n   [6] = '{200, 400, 200,  60, 300, 100};
   int ph_en  [6] = '{100,  97, 100, 100,  85, 100};
   int ph_hit [6] = '{ 30,  40,  20, 100,  35,  10};
   int ph_clr [6] = '{  0,   2,   0,   0,   3,   0};
   int ph_rdy [6] = '{100,  50,   5,  60,  70, 100};

   initial begin
      model_reset();
      rstn = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1 drive(50, 50, 50, 50);
         @(negedge clk);
         check_zero("rst");
      end
      en = 0; hit = 0; clr = 0; rpt_ready = 0;
      @(negedge clk);
      #1 rstn = 1;
      mon_on = 1;

      for (int p = 0; p < 6; p++) begin
         for (int c = 0; c < ph_n[p]; c++) begin
            @(posedge clk);
            #1 model_step(en, hit, clr, rpt_ready);
            if (p == 4 && c == 150) async_reset();
            else drive(ph_en[p], ph_hit[p], ph_clr[p], ph_rdy[p]);
         end
      end

      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1 model_step(en, hit, clr, rpt_ready);
         en = 0; hit = 0; clr = 0; rpt_ready = 1;
      end
      @(negedge clk);
      check("drain_reports", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
